mu_arbiter: RTL and testbench

- Two-master arbiter for the MemoryUnit request port (address/data/we/start/busy/q).
- Lets the CPU (master 0) and a second requester share the single MemoryUnit port. The second requester is the planned DMA/blitter for VRAM32/VRAM8 fills.
- Sits between the masters and MemoryUnit. Each master sees a private copy of the MemoryUnit handshake.
- Latches each request, picks a winner, sequences the MemoryUnit start/busy handshake and returns q to the owner.

---
 rtl/mu_port_if.sv | 23 ++
 rtl/mu_arbiter.sv | 125 ++++++++++++
 tb/tb_mu_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mu_port_if.sv
// MemoryUnit-style request port: address/data/we/start in, busy/q back.
// One instance per master plus one toward the MemoryUnit itself.
interface mu_port_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              we;
    logic              start;
    logic              busy;
    logic [DATA_W-1:0] q;

    modport master (
        output address, data, we, start,
        input  busy, q
    );

    modport slave (
        input  address, data, we, start,
        output busy, q
    );
endinterface

// File: rtl/mu_arbiter.sv
// Two-master arbiter sharing one MemoryUnit request port.
// Requests are latched, arbitrated, sequenced through start/busy, q returned.
module mu_arbiter #(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input logic       clk,
    input logic       reset,
    mu_port_if.slave  m0,
    mu_port_if.slave  m1,
    mu_port_if.master mu
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        pend;
    logic              owner;
    logic              last_grant;
    logic              win;
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_data [2];
    logic [1:0]        req_we;
    logic [1:0]        start_v;
    logic [1:0]        busy_v;
    logic [1:0]        take;
    logic [ADDR_W-1:0] in_addr [2];
    logic [DATA_W-1:0] in_data [2];
    logic [1:0]        in_we;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              we_q;
    logic              start_q;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;

    assign start_v    = {m1.start, m0.start};
    assign in_addr[0] = m0.address;
    assign in_addr[1] = m1.address;
    assign in_data[0] = m0.data;
    assign in_data[1] = m1.data;
    assign in_we      = {m1.we, m0.we};

    // Busy covers both the queued and the in-service phase of a request.
    assign busy_v[0] = pend[0] | ((state != IDLE) & ~owner);
    assign busy_v[1] = pend[1] | ((state != IDLE) & owner);
    assign take      = start_v & ~busy_v;

    always_comb begin
        win = 1'b0;
        unique case (1'b1)
            pend == 2'b11: win = ROUND_ROBIN ? ~last_grant : 1'b0;
            pend == 2'b10: win = 1'b1;
            default:       win = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pend       <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            req_we     <= '0;
            for (int i = 0; i < 2; i++) begin
                req_addr[i] <= '0;
                req_data[i] <= '0;
            end
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            start_q <= 1'b0;
            q0      <= '0;
            q1      <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (take[i]) begin
                    req_addr[i] <= in_addr[i];
                    req_data[i] <= in_data[i];
                    req_we[i]   <= in_we[i];
                    pend[i]     <= 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (|pend) begin
                        addr_q     <= req_addr[win];
                        data_q     <= req_data[win];
                        we_q       <= req_we[win];
                        start_q    <= 1'b1;
                        owner      <= win;
                        last_grant <= win;
                        pend[win]  <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mu.busy) begin
                        start_q <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mu.busy) begin
                        if (owner) q1 <= mu.q;
                        else       q0 <= mu.q;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mu.address = addr_q;
    assign mu.data    = data_q;
    assign mu.we      = we_q;
    assign mu.start   = start_q;
    assign m0.busy    = busy_v[0];
    assign m1.busy    = busy_v[1];
    assign m0.q       = q0;
    assign m1.q       = q1;
endmodule

// File: tb/tb_mu_arbiter.sv
// Directed bench for mu_arbiter: round-robin instance A, fixed-priority B.
// Each instance talks to a small MemoryUnit model with a 4-cycle busy.
module tb_mu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mu_port_if #(27, 32) a0 ();
    mu_port_if #(27, 32) a1 ();
    mu_port_if #(27, 32) amu ();
    mu_port_if #(27, 32) b0 ();
    mu_port_if #(27, 32) b1 ();
    mu_port_if #(27, 32) bmu ();

    mu_arbiter #(.ADDR_W(27), .DATA_W(32), .ROUND_ROBIN(1'b1)) dut_a (
        .clk(clk), .reset(rst), .m0(a0), .m1(a1), .mu(amu)
    );
    mu_arbiter #(.ADDR_W(27), .DATA_W(32), .ROUND_ROBIN(1'b0)) dut_b (
        .clk(clk), .reset(rst), .m0(b0), .m1(b1), .mu(bmu)
    );

    logic [31:0] rdata_a = 32'h0;
    logic [31:0] rdata_b = 32'h0;
    assign amu.q = rdata_a;
    assign bmu.q = rdata_b;

    logic [26:0] alog [32];
    logic [26:0] blog [32];
    int          an = 0;
    int          bn = 0;
    int          acnt = 0;
    int          bcnt = 0;

    // Busy rises one cycle after start is seen and stays high 4 cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            amu.busy <= 1'b0;
            acnt     <= 0;
        end else if (!amu.busy && amu.start) begin
            amu.busy  <= 1'b1;
            acnt      <= 4;
            alog[an]  <= amu.address;
            an        <= an + 1;
        end else if (amu.busy) begin
            if (acnt == 1) amu.busy <= 1'b0;
            acnt <= acnt - 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bmu.busy <= 1'b0;
            bcnt     <= 0;
        end else if (!bmu.busy && bmu.start) begin
            bmu.busy  <= 1'b1;
            bcnt      <= 4;
            blog[bn]  <= bmu.address;
            bn        <= bn + 1;
        end else if (bmu.busy) begin
            if (bcnt == 1) bmu.busy <= 1'b0;
            bcnt <= bcnt - 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input bit s0, input bit s1,
                           input logic [26:0] ad0, input logic [26:0] ad1,
                           input logic [31:0] d1, input bit w1);
        a0.address = ad0; a0.data = 32'h0; a0.we = 1'b0; a0.start = s0;
        a1.address = ad1; a1.data = d1;    a1.we = w1;   a1.start = s1;
        step();
        a0.start = 1'b0;
        a1.start = 1'b0;
    endtask

    task automatic drive_b(input bit s0, input bit s1,
                           input logic [26:0] ad0, input logic [26:0] ad1);
        b0.address = ad0; b0.data = 32'h0; b0.we = 1'b0; b0.start = s0;
        b1.address = ad1; b1.data = 32'h0; b1.we = 1'b0; b1.start = s1;
        step();
        b0.start = 1'b0;
        b1.start = 1'b0;
    endtask

    task automatic wait_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!a0.busy && !a1.busy && !amu.busy && !amu.start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_b(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!b0.busy && !b1.busy && !bmu.busy && !bmu.start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        tests++;
        if ({amu.start, amu.we, a0.busy, a1.busy} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 0000",
                     {amu.start, amu.we, a0.busy, a1.busy});
        end
        tests++;
        if (amu.address !== 27'h0 || amu.data !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus: got %h/%h want 0/0", amu.address, amu.data);
        end
        tests++;
        if (a0.q !== 32'h0 || a1.q !== 32'h0) begin
            fails++;
            $display("FAIL reset_q: got %h/%h want 0/0", a0.q, a1.q);
        end
        tests++;
        if ({bmu.start, b0.busy, b1.busy} !== 3'b0) begin
            fails++;
            $display("FAIL reset_b: got %b want 000", {bmu.start, b0.busy, b1.busy});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        bit m1_seen = 1'b0;
        rdata_a = 32'hDEADBEEF;
        drive_a(1'b1, 1'b0, 27'h0000123, 27'h0, 32'h0, 1'b0);
        tests++;
        if (a0.busy !== 1'b1 || amu.start !== 1'b0) begin
            fails++;
            $display("FAIL sr_capture: busy=%b start=%b want 1/0", a0.busy, amu.start);
        end
        step();
        tests++;
        if (amu.start !== 1'b1 || amu.address !== 27'h0000123 || amu.we !== 1'b0) begin
            fails++;
            $display("FAIL sr_grant: start=%b addr=%h we=%b want 1/0000123/0",
                     amu.start, amu.address, amu.we);
        end
        step();
        tests++;
        if (amu.start !== 1'b1) begin
            fails++;
            $display("FAIL sr_hold: start=%b want 1", amu.start);
        end
        step();
        tests++;
        if (amu.start !== 1'b0) begin
            fails++;
            $display("FAIL sr_drop: start=%b want 0", amu.start);
        end
        for (int i = 0; i < 3; i++) begin
            if (a1.busy) m1_seen = 1'b1;
            step();
        end
        tests++;
        if (a0.busy !== 1'b1 || a0.q !== 32'h0) begin
            fails++;
            $display("FAIL sr_pre: busy=%b q=%h want 1/0", a0.busy, a0.q);
        end
        step();
        tests++;
        if (a0.busy !== 1'b0 || a0.q !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL sr_done: busy=%b q=%h want 0/deadbeef", a0.busy, a0.q);
        end
        tests++;
        if (m1_seen || a1.busy !== 1'b0 || a1.q !== 32'h0) begin
            fails++;
            $display("FAIL sr_m1: busy=%b q=%h want 0/0", a1.busy, a1.q);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        bit m1_drop = 1'b0;
        int base;
        pulse_reset();
        rdata_a = 32'h11110000;
        base = an;
        drive_a(1'b1, 1'b1, 27'h10, 27'h20, 32'h0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            step();
            if (!a0.busy) break;
            if (!a1.busy) m1_drop = 1'b1;
        end
        tests++;
        if (m1_drop || a1.busy !== 1'b1) begin
            fails++;
            $display("FAIL sim_m1_busy: drop=%b busy=%b want 0/1", m1_drop, a1.busy);
        end
        wait_a(ok);
        tests++;
        if (!ok || an - base !== 2 || alog[base] !== 27'h10 || alog[base+1] !== 27'h20) begin
            fails++;
            $display("FAIL sim_order1: ok=%b n=%0d got %h,%h want 10,20",
                     ok, an - base, alog[base], alog[base+1]);
        end
        drive_a(1'b1, 1'b0, 27'h30, 27'h0, 32'h0, 1'b0);
        wait_a(ok);
        base = an;
        drive_a(1'b1, 1'b1, 27'h10, 27'h20, 32'h0, 1'b0);
        wait_a(ok);
        tests++;
        if (!ok || an - base !== 2 || alog[base] !== 27'h20 || alog[base+1] !== 27'h10) begin
            fails++;
            $display("FAIL sim_order2: ok=%b n=%0d got %h,%h want 20,10",
                     ok, an - base, alog[base], alog[base+1]);
        end
    endtask

    task automatic test_write();
        bit ok;
        bit bad = 1'b0;
        int cyc = 0;
        drive_a(1'b0, 1'b1, 27'h0, 27'h0C00000, 32'h12345678, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (amu.start) begin
                cyc++;
                if (amu.address !== 27'h0C00000 || amu.data !== 32'h12345678 ||
                    amu.we !== 1'b1) bad = 1'b1;
            end
        end
        tests++;
        if (bad || cyc !== 2) begin
            fails++;
            $display("FAIL wr_pass: bad=%b issue_cycles=%0d want 0/2", bad, cyc);
        end
        wait_a(ok);
        tests++;
        if (!ok || amu.we !== 1'b1 || amu.data !== 32'h12345678) begin
            fails++;
            $display("FAIL wr_hold: ok=%b we=%b data=%h want 1/1/12345678",
                     ok, amu.we, amu.data);
        end
    endtask

    task automatic test_restart();
        bit ok;
        int base = an;
        drive_a(1'b1, 1'b0, 27'h100, 27'h0, 32'h0, 1'b0);
        step();
        drive_a(1'b1, 1'b0, 27'h200, 27'h0, 32'h0, 1'b0);
        tests++;
        if (amu.address !== 27'h100) begin
            fails++;
            $display("FAIL rs_addr: got %h want 100", amu.address);
        end
        wait_a(ok);
        tests++;
        if (!ok || an - base !== 1 || alog[base] !== 27'h100) begin
            fails++;
            $display("FAIL rs_once: ok=%b n=%0d addr=%h want 1/1/100",
                     ok, an - base, alog[base]);
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        bit hit = 1'b0;
        rdata_a = 32'hCAFEF00D;
        drive_a(1'b1, 1'b0, 27'h40, 27'h0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (amu.busy && !amu.start) begin
                hit = 1'b1;
                break;
            end
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL mid_wait: reached_wait=%b want 1", hit);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({amu.start, a0.busy, a1.busy} !== 3'b0 || a0.q !== 32'h0 || a1.q !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: ctl=%b q0=%h q1=%h want 000/0/0",
                     {amu.start, a0.busy, a1.busy}, a0.q, a1.q);
        end
        step();
        rst = 1'b0;
        rdata_a = 32'h5A5A1234;
        drive_a(1'b1, 1'b0, 27'h44, 27'h0, 32'h0, 1'b0);
        wait_a(ok);
        tests++;
        if (!ok || a0.q !== 32'h5A5A1234 || a1.q !== 32'h0) begin
            fails++;
            $display("FAIL mid_fresh: ok=%b q0=%h q1=%h want 1/5a5a1234/0",
                     ok, a0.q, a1.q);
        end
    endtask

    task automatic test_fixed_priority();
        bit ok;
        int base = bn;
        rdata_b = 32'h0BADF00D;
        drive_b(1'b1, 1'b1, 27'h10, 27'h20);
        wait_b(ok);
        drive_b(1'b1, 1'b1, 27'h30, 27'h40);
        wait_b(ok);
        tests++;
        if (!ok || bn - base !== 4 || blog[base] !== 27'h10 || blog[base+1] !== 27'h20 ||
            blog[base+2] !== 27'h30 || blog[base+3] !== 27'h40) begin
            fails++;
            $display("FAIL fp_order: n=%0d got %h,%h,%h,%h want 10,20,30,40",
                     bn - base, blog[base], blog[base+1], blog[base+2], blog[base+3]);
        end
        tests++;
        if (b0.q !== 32'h0BADF00D || b1.q !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL fp_q: q0=%h q1=%h want 0badf00d", b0.q, b1.q);
        end
        base = bn;
        drive_b(1'b0, 1'b1, 27'h0, 27'h50);
        wait_b(ok);
        tests++;
        if (!ok || bn - base !== 1 || blog[base] !== 27'h50) begin
            fails++;
            $display("FAIL fp_alone: ok=%b n=%0d addr=%h want 1/1/50",
                     ok, bn - base, blog[base]);
        end
    endtask

    initial begin
        a0.address = '0; a0.data = '0; a0.we = 1'b0; a0.start = 1'b0;
        a1.address = '0; a1.data = '0; a1.we = 1'b0; a1.start = 1'b0;
        b0.address = '0; b0.data = '0; b0.we = 1'b0; b0.start = 1'b0;
        b1.address = '0; b1.data = '0; b1.we = 1'b0; b1.start = 1'b0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write();
        test_restart();
        test_reset_midop();
        test_fixed_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
